// File: rtl/rr_arbiter_n_pkg.sv
// Shared definitions for the N-requester arbiter: mode codes, FSM states, width helper.
package rr_arbiter_n_pkg;

    localparam int unsigned MODE_RR    = 0;
    localparam int unsigned MODE_FIXED = 1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // ceil(log2(n)) with a floor of one bit so single-value fields stay declarable
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Requester-side bus of the arbiter: enable, request vector and the registered grant.
interface rr_arbiter_n_if
    import rr_arbiter_n_pkg::*;
#(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned ID_W = clog2_min1(N_REQ);

    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_vld;
    logic [ID_W-1:0]  gnt_id;

    modport master (output en, req, input gnt, gnt_vld, gnt_id);
    modport slave  (input en, req, output gnt, gnt_vld, gnt_id);

endinterface

// File: rtl/rr_arbiter_n_pick.sv
// Combinational winner picker: first set bit of (req & mask) scanning upward from start, wrapping.
module rr_arbiter_n_pick
    import rr_arbiter_n_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]                 req,
    input  logic [N_REQ-1:0]                 mask,
    input  logic [clog2_min1(N_REQ)-1:0]     start,
    output logic                             found,
    output logic [clog2_min1(N_REQ)-1:0]     idx
);
    localparam int unsigned ID_W = clog2_min1(N_REQ);

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] rot;

    assign cand = req & mask;

    // Rotate candidates so start sits at bit 0, priority-encode, then undo the rotation
    always_comb begin
        int unsigned off;
        rot   = '0;
        found = 1'b0;
        off   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rot[i] = cand[ID_W'((32'(start) + i) % N_REQ)];
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = i;
            end
        end
        idx = ID_W'((32'(start) + off) % N_REQ);
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-requester arbiter with round-robin or fixed priority and a bounded tenure while others wait.
module rr_arbiter_n
    import rr_arbiter_n_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MODE     = MODE_RR,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    rr_arbiter_n_if.slave bus
);
    localparam int unsigned     ID_W      = clog2_min1(N_REQ);
    localparam int unsigned     HC_W      = clog2_min1(HOLD_MAX + 1);
    localparam int unsigned     HOLD_LAST = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             vld_q, vld_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [HC_W-1:0]  hold_q, hold_d;
    logic [ID_W-1:0]  last_q, last_d;

    logic [ID_W-1:0]  rr_start;
    logic [ID_W-1:0]  start_c;
    logic             found_c;
    logic [ID_W-1:0]  win_c;
    logic [N_REQ-1:0] win_oh;
    logic             own_req;

    // Scan origin: one past the last winner for round-robin, index 0 for fixed priority
    assign rr_start = (last_q == LAST_IDX) ? '0 : last_q + ID_W'(1);
    assign start_c  = (MODE == MODE_FIXED) ? '0 : rr_start;
    assign win_oh   = N_REQ'(1) << win_c;
    assign own_req  = |(bus.req & gnt_q);

    // Current owner is masked out, so found_c means "someone else is pending" while granted
    rr_arbiter_n_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (bus.req),
        .mask  (~gnt_q),
        .start (start_c),
        .found (found_c),
        .idx   (win_c)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        vld_d   = vld_q;
        id_d    = id_q;
        hold_d  = hold_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (bus.en && found_c) begin
                    state_d = ARB_GRANT;
                    gnt_d   = win_oh;
                    vld_d   = 1'b1;
                    id_d    = win_c;
                    hold_d  = '0;
                    last_d  = win_c;
                end
            end
            ARB_GRANT: begin
                if (!bus.en) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    hold_d  = '0;
                end else if (!own_req || (found_c && HOLD_MAX != 0 &&
                                          hold_q == HC_W'(HOLD_LAST))) begin
                    // Owner released or tenure expired: hand over on this edge, no gap
                    if (found_c) begin
                        gnt_d  = win_oh;
                        id_d   = win_c;
                        hold_d = '0;
                        last_d = win_c;
                    end else begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                        hold_d  = '0;
                    end
                end else if (!found_c) begin
                    hold_d = '0;
                end else if (HOLD_MAX != 0) begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            hold_q  <= '0;
            last_q  <= LAST_IDX;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_vld = vld_q;
    assign bus.gnt_id  = id_q;

endmodule
